ep2_frame_decoder: RTL and testbench

//  Consumes the 1024-byte EP2 payload stream that the old-protocol RX receiver writes toward its FIFO.

---
 rtl/ep2_pkg.sv | 45 ++++
 rtl/ep2_byte_shift.sv | 40 ++++
 rtl/ep2_frame_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_ep2_frame_decoder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ep2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ep2_pkg
// Purpose  : Shared constants, state encoding and helpers for the EP2 frame
//            decoder (old-protocol host->radio payload parser).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ep2_pkg;

  // Frame layout
  localparam logic [7:0] SYNC_BYTE     = 8'h7F;
  localparam int         FRAME_BYTES   = 512;
  localparam int         SAMPLE_BYTES  = 8;
  localparam logic [8:0] CC_OFFSET     = 9'd3;   // first command byte (C0)
  localparam logic [8:0] SAMPLE_OFFSET = 9'd8;   // first sample byte

  // Last byte index of each region, used as the transition points
  localparam logic [8:0] SYNC_LAST  = CC_OFFSET - 9'd1;
  localparam logic [8:0] CC_LAST    = SAMPLE_OFFSET - 9'd1;
  localparam logic [8:0] FRAME_LAST = 9'(FRAME_BYTES - 1);
  localparam logic [2:0] GROUP_LAST = 3'(SAMPLE_BYTES - 1);

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_CC      = 3'd2;
  localparam logic [2:0] ST_SAMPLES = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SYNC    = ST_SYNC,
    S_CC      = ST_CC,
    S_SAMPLES = ST_SAMPLES,
    S_DISCARD = ST_DISCARD
  } state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage : ep2_pkg
`default_nettype wire

// File: rtl/ep2_byte_shift.sv
`default_nettype none
// ============================================================================
// Module   : ep2_byte_shift
// Purpose  : 64-bit big-endian byte shift register. Each enabled cycle the
//            register moves up one byte and din enters the low byte, so after
//            N shifts the last N bytes appear in arrival order, MSB first.
//            word_next is the look-ahead value (contents after this edge),
//            letting the consumer capture a completed word on the same edge
//            its final byte is shifted in.
// Ports    : clk       in   1   clock, rising edge
//            rst_n     in   1   asynchronous active-low reset
//            shift_en  in   1   shift din in this cycle
//            din       in   8   byte to shift in
//            word_next out  64  register contents after this cycle's edge
// Revision : 1.0 - initial release
// ============================================================================
module ep2_byte_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [63:0] word_next
);

  logic [63:0] word_q;

  always_comb begin
    word_next = shift_en ? {word_q[55:0], din} : word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 64'd0;
    end else begin
      word_q <= word_next;
    end
  end

endmodule : ep2_byte_shift
`default_nettype wire

// File: rtl/ep2_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ep2_frame_decoder
// Purpose  : Parses the 1024-byte EP2 payload (two 512-byte frames of
//            3 sync bytes, C0..C4, 63 x 8-byte L/R/I/Q groups) into command
//            words for the config bank and TX IQ/audio samples.
// Ports    : rx_clk        in   1   receive clock, rising edge
//            rst_n         in   1   asynchronous active-low reset
//            run           in   1   gates sample output only
//            data_in       in   8   payload byte
//            data_valid    in   1   byte qualifier, contiguous per payload
//            cmd_valid     out  1   strobe: new command word
//            cmd_addr      out  7   C0[7:1]
//            cmd_mox       out  1   C0[0]
//            cmd_data      out  32  {C1,C2,C3,C4}
//            sample_valid  out  1   strobe: new sample group
//            audio_l/r     out  16  signed audio
//            tx_i/tx_q     out  16  signed TX IQ
//            frame_cnt     out  16  good frames, saturating
//            sync_err_cnt  out  16  dropped frames, saturating
// Revision : 1.0 - initial release
// ============================================================================
module ep2_frame_decoder
  import ep2_pkg::*;
(
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        cmd_valid,
  output logic [6:0]  cmd_addr,
  output logic        cmd_mox,
  output logic [31:0] cmd_data,
  output logic        sample_valid,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic [15:0] tx_i,
  output logic [15:0] tx_q,
  output logic [15:0] frame_cnt,
  output logic [15:0] sync_err_cnt
);

  state_t      state, state_nx;
  logic [8:0]  byte_cnt, byte_cnt_nx;
  logic [2:0]  grp_byte, grp_byte_nx;   // position within current sample group
  logic        shift_en;
  logic [63:0] word_next;
  logic        cmd_done;
  logic        grp_done;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt_q;
  logic [15:0] sync_err_cnt_q;

  ep2_byte_shift u_shift (
    .clk       (rx_clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .din       (data_in),
    .word_next (word_next)
  );

  // --------------------------------------------------------------------------
  // Next-state logic. The byte that leaves IDLE is byte 0 of a frame, so its
  // sync check happens in IDLE; a frame end also returns to IDLE, which makes
  // the next contiguous byte byte 0 of the following frame and makes a gap at
  // a frame boundary harmless.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    grp_byte_nx = grp_byte;
    shift_en    = 1'b0;
    cmd_done    = 1'b0;
    grp_done    = 1'b0;
    frame_done  = 1'b0;
    frame_err   = 1'b0;

    case (state)
      S_IDLE: begin
        if (data_valid) begin
          if (data_in == SYNC_BYTE) begin
            state_nx    = S_SYNC;
            byte_cnt_nx = 9'd1;
          end else begin
            state_nx    = S_DISCARD;
            byte_cnt_nx = 9'd0;
            frame_err   = 1'b1;
          end
        end
      end

      S_SYNC: begin
        if (!data_valid) begin
          state_nx    = S_IDLE;
          byte_cnt_nx = 9'd0;
          frame_err   = 1'b1;
        end else if (data_in != SYNC_BYTE) begin
          state_nx    = S_DISCARD;
          byte_cnt_nx = 9'd0;
          frame_err   = 1'b1;
        end else begin
          byte_cnt_nx = byte_cnt + 9'd1;
          if (byte_cnt == SYNC_LAST) begin
            state_nx = S_CC;
          end
        end
      end

      S_CC: begin
        if (!data_valid) begin
          state_nx    = S_IDLE;
          byte_cnt_nx = 9'd0;
          frame_err   = 1'b1;
        end else begin
          shift_en    = 1'b1;
          byte_cnt_nx = byte_cnt + 9'd1;
          if (byte_cnt == CC_LAST) begin
            cmd_done    = 1'b1;
            state_nx    = S_SAMPLES;
            grp_byte_nx = 3'd0;
          end
        end
      end

      S_SAMPLES: begin
        if (!data_valid) begin
          state_nx    = S_IDLE;
          byte_cnt_nx = 9'd0;
          frame_err   = 1'b1;
        end else begin
          shift_en    = 1'b1;
          grp_byte_nx = grp_byte + 3'd1;
          grp_done    = (grp_byte == GROUP_LAST);
          if (byte_cnt == FRAME_LAST) begin
            frame_done  = 1'b1;
            state_nx    = S_IDLE;
            byte_cnt_nx = 9'd0;
          end else begin
            byte_cnt_nx = byte_cnt + 9'd1;
          end
        end
      end

      S_DISCARD: begin
        if (!data_valid) begin
          state_nx    = S_IDLE;
          byte_cnt_nx = 9'd0;
        end
      end

      default: begin
        state_nx    = S_IDLE;
        byte_cnt_nx = 9'd0;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_cnt <= 9'd0;
      grp_byte <= 3'd0;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_cnt_nx;
      grp_byte <= grp_byte_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers. Captures use the shifter's look-ahead word so the data
  // is valid in the same cycle as its strobe.
  // --------------------------------------------------------------------------
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= 7'd0;
      cmd_mox   <= 1'b0;
      cmd_data  <= 32'd0;
    end else begin
      cmd_valid <= cmd_done;
      if (cmd_done) begin
        cmd_addr <= word_next[39:33];
        cmd_mox  <= word_next[32];
        cmd_data <= word_next[31:0];
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      audio_l      <= 16'd0;
      audio_r      <= 16'd0;
      tx_i         <= 16'd0;
      tx_q         <= 16'd0;
    end else begin
      sample_valid <= grp_done & run;
      if (grp_done && run) begin
        audio_l <= word_next[63:48];
        audio_r <= word_next[47:32];
        tx_i    <= word_next[31:16];
        tx_q    <= word_next[15:0];
      end
    end
  end

  // Counters update independently of each other
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q    <= 16'd0;
      sync_err_cnt_q <= 16'd0;
    end else begin
      if (frame_done) begin
        frame_cnt_q <= sat_inc16(frame_cnt_q);
      end
      if (frame_err) begin
        sync_err_cnt_q <= sat_inc16(sync_err_cnt_q);
      end
    end
  end

  assign frame_cnt    = frame_cnt_q;
  assign sync_err_cnt = sync_err_cnt_q;

endmodule : ep2_frame_decoder
`default_nettype wire

// File: tb/tb_ep2_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ep2_frame_decoder
// Purpose  : Self-checking bench for ep2_frame_decoder. Payloads are built as
//            byte queues; a frame-level reference model parses the same queue
//            and predicts the command words, sample groups and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ep2_frame_decoder;

  logic        rx_clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic        cmd_mox;
  logic [31:0] cmd_data;
  logic        sample_valid;
  logic [15:0] audio_l, audio_r, tx_i, tx_q;
  logic [15:0] frame_cnt, sync_err_cnt;

  ep2_frame_decoder dut (
    .rx_clk       (rx_clk),
    .rst_n        (rst_n),
    .run          (run),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .cmd_valid    (cmd_valid),
    .cmd_addr     (cmd_addr),
    .cmd_mox      (cmd_mox),
    .cmd_data     (cmd_data),
    .sample_valid (sample_valid),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .tx_i         (tx_i),
    .tx_q         (tx_q),
    .frame_cnt    (frame_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  pl[$];
  logic        pl_run[$];
  logic [39:0] exp_cmd[$], obs_cmd[$];
  logic [63:0] exp_smp[$], obs_smp[$];
  logic [15:0] exp_frame, exp_err;
  logic        overlap;

  // Observe strobes mid-cycle
  always @(negedge rx_clk) begin
    if (cmd_valid)    obs_cmd.push_back({cmd_addr, cmd_mox, cmd_data});
    if (sample_valid) obs_smp.push_back({audio_l, audio_r, tx_i, tx_q});
    if (cmd_valid && sample_valid) overlap = 1'b1;
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame-level reference: walk the payload 512 bytes at a time
  function automatic void model_payload();
    int len;
    int pos;
    int base;
    len = pl.size();
    pos = 0;
    while (pos < len) begin
      for (int k = 0; k < 3; k++) begin
        if ((pos + k >= len) || (pl[pos+k] != 8'h7F)) begin
          exp_err = sat16(exp_err);
          return;
        end
      end
      if (pos + 8 > len) begin
        exp_err = sat16(exp_err);
        return;
      end
      exp_cmd.push_back({pl[pos+3], pl[pos+4], pl[pos+5], pl[pos+6], pl[pos+7]});
      for (int g = 0; g < 63; g++) begin
        base = pos + 8 + 8 * g;
        if (base + 8 > len) begin
          exp_err = sat16(exp_err);
          return;
        end
        if (pl_run[base+7])
          exp_smp.push_back({pl[base], pl[base+1], pl[base+2], pl[base+3],
                             pl[base+4], pl[base+5], pl[base+6], pl[base+7]});
      end
      exp_frame = sat16(exp_frame);
      pos += 512;
    end
  endfunction

  task automatic add_frame(input logic [7:0] c0, input logic [31:0] cd, input logic r);
    for (int k = 0; k < 3; k++) pl.push_back(8'h7F);
    pl.push_back(c0);
    pl.push_back(cd[31:24]);
    pl.push_back(cd[23:16]);
    pl.push_back(cd[15:8]);
    pl.push_back(cd[7:0]);
    for (int k = 0; k < 504; k++) pl.push_back(8'($urandom));
    for (int k = 0; k < 512; k++) pl_run.push_back(r);
  endtask

  task automatic drive_payload(input int gap);
    for (int i = 0; i < pl.size(); i++) begin
      data_valid = 1'b1;
      data_in    = pl[i];
      run        = pl_run[i];
      @(posedge rx_clk); #1;
    end
    data_valid = 1'b0;
    data_in    = 8'($urandom);
    repeat (gap) @(posedge rx_clk);
    #1;
  endtask

  task automatic send(input int gap);
    model_payload();
    drive_payload(gap);
    pl.delete();
    pl_run.delete();
  endtask

  task automatic apply_reset();
    data_valid = 1'b0;
    data_in    = 8'h00;
    run        = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1;
    rst_n = 1'b1;
    obs_cmd.delete(); obs_smp.delete();
    exp_cmd.delete(); exp_smp.delete();
    pl.delete(); pl_run.delete();
    exp_frame = 16'd0;
    exp_err   = 16'd0;
    overlap   = 1'b0;
    @(posedge rx_clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({cmd_valid, sample_valid} !== 2'b00) begin bad++;
      $display("FAIL reset_strobes: got %b want 00", {cmd_valid, sample_valid}); end
    total++; if ({cmd_addr, cmd_mox, cmd_data} !== 40'd0) begin bad++;
      $display("FAIL reset_cmd: got %h want 0", {cmd_addr, cmd_mox, cmd_data}); end
    total++; if ({audio_l, audio_r, tx_i, tx_q} !== 64'd0) begin bad++;
      $display("FAIL reset_samples: got %h want 0", {audio_l, audio_r, tx_i, tx_q}); end
    total++; if ({frame_cnt, sync_err_cnt} !== 32'd0) begin bad++;
      $display("FAIL reset_counters: got %h want 0", {frame_cnt, sync_err_cnt}); end
  endtask

  task automatic test_run_off();
    apply_reset();
    add_frame(8'h01, 32'hDEADBEEF, 1'b0);
    add_frame(8'h01, 32'hDEADBEEF, 1'b0);
    send(3);
    total++; if (obs_cmd.size() !== 2) begin bad++;
      $display("FAIL runoff_cmd_count: got %0d want 2", obs_cmd.size()); end
    total++; if (obs_smp.size() !== 0) begin bad++;
      $display("FAIL runoff_smp_count: got %0d want 0", obs_smp.size()); end
    total++; if ({audio_l, audio_r, tx_i, tx_q} !== 64'd0) begin bad++;
      $display("FAIL runoff_samples_held: got %h want 0", {audio_l, audio_r, tx_i, tx_q}); end
    total++; if (frame_cnt !== 16'd2) begin bad++;
      $display("FAIL runoff_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_good_payload();
    int nd;
    apply_reset();
    add_frame(8'h01, 32'hDEADBEEF, 1'b1);
    add_frame(8'h01, 32'hDEADBEEF, 1'b1);
    pl[8] = 8'h00; pl[9]  = 8'h01; pl[10] = 8'h00; pl[11] = 8'h02;
    pl[12] = 8'h7F; pl[13] = 8'hFF; pl[14] = 8'h80; pl[15] = 8'h00;
    send(3);
    total++; if (obs_cmd.size() !== 2) begin bad++;
      $display("FAIL good_cmd_count: got %0d want 2", obs_cmd.size()); end
    total++; if ({cmd_addr, cmd_mox, cmd_data} !== {7'd0, 1'b1, 32'hDEADBEEF}) begin bad++;
      $display("FAIL good_cmd_fields: got %h want 01deadbeef", {cmd_addr, cmd_mox, cmd_data}); end
    total++; if (obs_smp.size() !== 126) begin bad++;
      $display("FAIL good_smp_count: got %0d want 126", obs_smp.size()); end
    total++; if ((obs_smp.size() == 0) || (obs_smp[0] !== 64'h0001_0002_7FFF_8000)) begin bad++;
      $display("FAIL good_first_group: got %h want 000100027fff8000",
               (obs_smp.size() == 0) ? 64'hx : obs_smp[0]); end
    nd = 0;
    for (int i = 0; i < exp_smp.size(); i++)
      if ((i >= obs_smp.size()) || (obs_smp[i] !== exp_smp[i])) nd++;
    total++; if (nd != 0) begin bad++;
      $display("FAIL good_smp_list: got %0d differing groups want 0", nd); end
    total++; if ({frame_cnt, sync_err_cnt} !== {16'd2, 16'd0}) begin bad++;
      $display("FAIL good_counters: got %0d/%0d want 2/0", frame_cnt, sync_err_cnt); end
    total++; if (overlap !== 1'b0) begin bad++;
      $display("FAIL good_strobe_overlap: got %b want 0", overlap); end
  endtask

  task automatic test_bad_sync();
    int nd;
    apply_reset();
    add_frame(8'h22, 32'h1234_5678, 1'b1);
    add_frame(8'h23, 32'h9ABC_DEF0, 1'b1);
    pl[513] = 8'h7E;
    send(3);
    total++; if ({obs_cmd.size(), obs_smp.size()} !== {32'd1, 32'd63}) begin bad++;
      $display("FAIL badsync_strobes: got %0d cmd %0d smp want 1 cmd 63 smp",
               obs_cmd.size(), obs_smp.size()); end
    total++; if ({frame_cnt, sync_err_cnt} !== {16'd1, 16'd1}) begin bad++;
      $display("FAIL badsync_counters: got %0d/%0d want 1/1", frame_cnt, sync_err_cnt); end
    add_frame(8'h31, 32'h0BAD_F00D, 1'b1);
    add_frame(8'h32, 32'hFEED_FACE, 1'b1);
    send(3);
    nd = 0;
    for (int i = 0; i < exp_cmd.size(); i++)
      if ((i >= obs_cmd.size()) || (obs_cmd[i] !== exp_cmd[i])) nd++;
    for (int i = 0; i < exp_smp.size(); i++)
      if ((i >= obs_smp.size()) || (obs_smp[i] !== exp_smp[i])) nd++;
    total++; if ((nd != 0) || (obs_smp.size() != exp_smp.size())) begin bad++;
      $display("FAIL badsync_recover_lists: got %0d diffs %0d smp want 0 diffs %0d smp",
               nd, obs_smp.size(), exp_smp.size()); end
    total++; if ({frame_cnt, sync_err_cnt} !== {exp_frame, exp_err}) begin bad++;
      $display("FAIL badsync_recover_counters: got %0d/%0d want %0d/%0d",
               frame_cnt, sync_err_cnt, exp_frame, exp_err); end
  endtask

  task automatic test_truncated();
    apply_reset();
    add_frame(8'h45, 32'hCAFE_0001, 1'b1);
    add_frame(8'h45, 32'hCAFE_0002, 1'b1);
    while (pl.size() > 301) begin void'(pl.pop_back()); void'(pl_run.pop_back()); end
    send(3);
    total++; if (obs_cmd.size() !== 1) begin bad++;
      $display("FAIL trunc_cmd_count: got %0d want 1", obs_cmd.size()); end
    total++; if (obs_smp.size() !== 36) begin bad++;
      $display("FAIL trunc_smp_count: got %0d want 36", obs_smp.size()); end
    total++; if ({frame_cnt, sync_err_cnt} !== {16'd0, 16'd1}) begin bad++;
      $display("FAIL trunc_counters: got %0d/%0d want 0/1", frame_cnt, sync_err_cnt); end
    // A clean payload right after shows the decoder went back to IDLE
    add_frame(8'h46, 32'hCAFE_0003, 1'b1);
    add_frame(8'h47, 32'hCAFE_0004, 1'b1);
    send(3);
    total++; if ({obs_cmd.size(), obs_smp.size()} !== {32'd3, 32'd162}) begin bad++;
      $display("FAIL trunc_recover: got %0d cmd %0d smp want 3 cmd 162 smp",
               obs_cmd.size(), obs_smp.size()); end
    total++; if ({cmd_addr, cmd_mox, cmd_data} !== {8'h47, 32'hCAFE_0004}) begin bad++;
      $display("FAIL trunc_recover_cmd: got %h want 47cafe0004", {cmd_addr, cmd_mox, cmd_data}); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    add_frame(8'h55, 32'h1111_2222, 1'b1);
    add_frame(8'h56, 32'h3333_4444, 1'b1);
    pl[101] = 8'h55;
    for (int i = 0; i < pl.size(); i++) begin
      if (i == 100) begin
        rst_n = 1'b0;
        #1;
        total++; if ({cmd_valid, sample_valid, cmd_addr, cmd_mox, cmd_data} !== 42'd0) begin bad++;
          $display("FAIL midrst_cmd_zero: got %h want 0",
                   {cmd_valid, sample_valid, cmd_addr, cmd_mox, cmd_data}); end
        total++; if ({audio_l, audio_r, tx_i, tx_q, frame_cnt, sync_err_cnt} !== 96'd0) begin bad++;
          $display("FAIL midrst_data_zero: got %h want 0",
                   {audio_l, audio_r, tx_i, tx_q, frame_cnt, sync_err_cnt}); end
        obs_cmd.delete(); obs_smp.delete();
      end else begin
        rst_n = 1'b1;
      end
      data_valid = 1'b1;
      data_in    = pl[i];
      run        = pl_run[i];
      @(posedge rx_clk); #1;
    end
    data_valid = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    // Decoder sees a fresh payload that starts at byte 101
    for (int i = 0; i < 101; i++) begin void'(pl.pop_front()); void'(pl_run.pop_front()); end
    model_payload();
    total++; if ({obs_cmd.size(), obs_smp.size()} !== {exp_cmd.size(), exp_smp.size()}) begin bad++;
      $display("FAIL midrst_strobes: got %0d cmd %0d smp want %0d cmd %0d smp",
               obs_cmd.size(), obs_smp.size(), exp_cmd.size(), exp_smp.size()); end
    total++; if ({frame_cnt, sync_err_cnt} !== {exp_frame, exp_err}) begin bad++;
      $display("FAIL midrst_counters: got %0d/%0d want %0d/%0d",
               frame_cnt, sync_err_cnt, exp_frame, exp_err); end
    total++; if (sync_err_cnt !== 16'd1) begin bad++;
      $display("FAIL midrst_err_one: got %0d want 1", sync_err_cnt); end
    pl.delete(); pl_run.delete();
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.frame_cnt_q = 16'hFFFE;
    @(posedge rx_clk); #1;
    release dut.frame_cnt_q;
    exp_frame = 16'hFFFE;
    add_frame(8'h02, 32'h0000_0001, 1'b1);
    add_frame(8'h02, 32'h0000_0002, 1'b1);
    send(3);
    total++; if (frame_cnt !== 16'hFFFF) begin bad++;
      $display("FAIL sat_reach: got %h want ffff", frame_cnt); end
    add_frame(8'h03, 32'h0000_0003, 1'b1);
    add_frame(8'h03, 32'h0000_0004, 1'b1);
    send(3);
    total++; if (frame_cnt !== exp_frame) begin bad++;
      $display("FAIL sat_hold: got %h want %h", frame_cnt, exp_frame); end
  endtask

  // Mixed random payloads with 1-cycle gaps, random run, corruption and truncation
  task automatic test_back_to_back_random();
    int nd;
    int mode;
    int idx;
    int newlen;
    apply_reset();
    for (int p = 0; p < 10; p++) begin
      add_frame(8'($urandom), $urandom, 1'b1);
      add_frame(8'($urandom), $urandom, 1'b1);
      for (int i = 0; i < pl_run.size(); i++) pl_run[i] = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        idx = $urandom_range(0, 1) * 512 + $urandom_range(0, 2);
        pl[idx] = 8'h7F ^ 8'($urandom_range(1, 255));
      end else if (mode == 2) begin
        newlen = $urandom_range(1, 1023);
        while (pl.size() > newlen) begin void'(pl.pop_back()); void'(pl_run.pop_back()); end
      end else if (mode == 3) begin
        while (pl.size() > 512) begin void'(pl.pop_back()); void'(pl_run.pop_back()); end
      end
      send(1);
    end
    repeat (2) @(posedge rx_clk);
    #1;
    nd = 0;
    for (int i = 0; i < exp_cmd.size(); i++)
      if ((i >= obs_cmd.size()) || (obs_cmd[i] !== exp_cmd[i])) nd++;
    total++; if ((nd != 0) || (obs_cmd.size() != exp_cmd.size())) begin bad++;
      $display("FAIL rand_cmd_list: got %0d diffs %0d cmds want 0 diffs %0d cmds",
               nd, obs_cmd.size(), exp_cmd.size()); end
    nd = 0;
    for (int i = 0; i < exp_smp.size(); i++)
      if ((i >= obs_smp.size()) || (obs_smp[i] !== exp_smp[i])) nd++;
    total++; if ((nd != 0) || (obs_smp.size() != exp_smp.size())) begin bad++;
      $display("FAIL rand_smp_list: got %0d diffs %0d smps want 0 diffs %0d smps",
               nd, obs_smp.size(), exp_smp.size()); end
    total++; if ({frame_cnt, sync_err_cnt} !== {exp_frame, exp_err}) begin bad++;
      $display("FAIL rand_counters: got %0d/%0d want %0d/%0d",
               frame_cnt, sync_err_cnt, exp_frame, exp_err); end
    total++; if (overlap !== 1'b0) begin bad++;
      $display("FAIL rand_strobe_overlap: got %b want 0", overlap); end
  endtask

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    overlap    = 1'b0;
    exp_frame  = 16'd0;
    exp_err    = 16'd0;
    test_reset();
    test_run_off();
    test_good_payload();
    test_bad_sync();
    test_truncated();
    test_reset_mid_frame();
    test_saturation();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run cannot hang
  initial begin
    #900000;
    $display("FAIL timeout: simulation still running at %0t want finished", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_ep2_frame_decoder
`default_nettype wire
